// File: rtl/fetch_sequencer.sv
// fetch_sequencer: owns the word-indexed PC of the non-pipelined MIPS core.
// It presents the PC to a one-cycle-latency instruction memory, captures the
// returned word, and holds it valid until the datapath reports completion.
// It then chooses the next PC from the sequential, branch and jump outcomes.
// It stops on the halt sentinel or on an out-of-range PC.
module fetch_sequencer #(
    parameter logic [31:0] PC_RESET  = 32'd0,
    parameter int unsigned MEM_DEPTH = 151,
    parameter logic [31:0] HALT_WORD = 32'hFFFF_FFFF,
    parameter int unsigned CNT_W     = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [31:0]      mem_instr,
    input  logic             exec_done,
    input  logic             take_branch,
    input  logic             take_jump,
    input  logic [15:0]      branch_imm,
    input  logic [25:0]      jump_target,
    output logic [31:0]      pc,
    output logic [31:0]      instr,
    output logic             instr_valid,
    output logic             halted,
    output logic             fault,
    output logic [CNT_W-1:0] retired_count
);

    localparam int unsigned     PC_W       = 32;
    localparam logic [PC_W-1:0] LP_DEPTH   = PC_W'(MEM_DEPTH);
    localparam logic [CNT_W-1:0] LP_CNT_MAX = '1;

    typedef enum logic [1:0] {
        S_FETCH   = 2'd0,
        S_CAPTURE = 2'd1,
        S_EXEC    = 2'd2,
        S_HALT    = 2'd3
    } state_t;

    state_t            r_state;
    logic [PC_W-1:0]   r_pc;
    logic [31:0]       r_instr;
    logic              r_valid;
    logic              r_halted;
    logic              r_fault;
    logic [CNT_W-1:0]  r_count;

    logic [PC_W-1:0]   w_pc_plus1;
    logic [PC_W-1:0]   w_branch_off;
    logic [PC_W-1:0]   w_branch_pc;
    logic [PC_W-1:0]   w_jump_pc;
    logic [PC_W-1:0]   w_next_pc;
    logic              w_pc_oob;
    logic              w_is_halt;
    logic [CNT_W-1:0]  w_count_inc;

    // Next-PC candidates; all arithmetic wraps at 32 bits.
    assign w_pc_plus1   = r_pc + PC_W'(1);
    assign w_branch_off = {{16{branch_imm[15]}}, branch_imm};
    assign w_branch_pc  = w_pc_plus1 + w_branch_off;
    assign w_jump_pc    = {w_pc_plus1[31:26], jump_target};

    // Jump outranks branch when both are flagged.
    assign w_next_pc = take_jump   ? w_jump_pc   :
                       take_branch ? w_branch_pc :
                                     w_pc_plus1;

    assign w_pc_oob    = (r_pc >= LP_DEPTH);
    assign w_is_halt   = (mem_instr == HALT_WORD);
    assign w_count_inc = (r_count == LP_CNT_MAX) ? r_count : r_count + CNT_W'(1);

    // Sequencer FSM: fetch, capture, execute, with a terminal halt state.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= S_FETCH;
            r_pc     <= PC_RESET;
            r_instr  <= 32'd0;
            r_valid  <= 1'b0;
            r_halted <= 1'b0;
            r_fault  <= 1'b0;
            r_count  <= '0;
        end else begin
            case (r_state)
                S_FETCH: begin
                    // Memory samples r_pc at this edge; a bad PC halts here.
                    if (w_pc_oob) begin
                        r_state  <= S_HALT;
                        r_halted <= 1'b1;
                        r_fault  <= 1'b1;
                    end else begin
                        r_state <= S_CAPTURE;
                    end
                end
                S_CAPTURE: begin
                    r_instr <= mem_instr;
                    if (w_is_halt) begin
                        r_state  <= S_HALT;
                        r_halted <= 1'b1;
                    end else begin
                        r_state <= S_EXEC;
                        r_valid <= 1'b1;
                    end
                end
                S_EXEC: begin
                    // Branch/jump inputs only matter on the completion edge.
                    if (exec_done) begin
                        r_state <= S_FETCH;
                        r_valid <= 1'b0;
                        r_pc    <= w_next_pc;
                        r_count <= w_count_inc;
                    end
                end
                S_HALT: begin
                    r_state <= S_HALT;
                    r_valid <= 1'b0;
                end
            endcase
        end
    end

    assign pc            = r_pc;
    assign instr         = r_instr;
    assign instr_valid   = r_valid;
    assign halted        = r_halted;
    assign fault         = r_fault;
    assign retired_count = r_count;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Bench for fetch_sequencer: a registered instruction memory and a
// transaction-level PC/count model, driven by directed and random programs.
module tb_fetch_sequencer;

    localparam int unsigned DEPTH = 151;
    localparam logic [31:0] HALTW = 32'hFFFF_FFFF;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] mem_instr;
    logic [31:0] mem_instr_s;
    logic        exec_done;
    logic        take_branch;
    logic        take_jump;
    logic [15:0] branch_imm;
    logic [25:0] jump_target;

    logic [31:0] pc, instr, pc_s, instr_s;
    logic        instr_valid, halted, fault;
    logic        valid_s, halted_s, fault_s;
    logic [31:0] retired_count;
    logic [1:0]  cnt_s;

    fetch_sequencer dut (
        .clk(clk), .rst(rst), .mem_instr(mem_instr), .exec_done(exec_done),
        .take_branch(take_branch), .take_jump(take_jump),
        .branch_imm(branch_imm), .jump_target(jump_target),
        .pc(pc), .instr(instr), .instr_valid(instr_valid),
        .halted(halted), .fault(fault), .retired_count(retired_count)
    );

    // Narrow-counter copy to exercise retired_count saturation.
    fetch_sequencer #(.CNT_W(2)) dut_s (
        .clk(clk), .rst(rst), .mem_instr(mem_instr_s), .exec_done(exec_done),
        .take_branch(take_branch), .take_jump(take_jump),
        .branch_imm(branch_imm), .jump_target(jump_target),
        .pc(pc_s), .instr(instr_s), .instr_valid(valid_s),
        .halted(halted_s), .fault(fault_s), .retired_count(cnt_s)
    );

    always #5 clk = ~clk;

    logic [31:0] mem [0:255];

    // Instruction memory with one-cycle registered read.
    always @(posedge clk) begin
        mem_instr   <= (pc   < 32'(DEPTH)) ? mem[pc[7:0]]   : 32'h0BAD_0BAD;
        mem_instr_s <= (pc_s < 32'(DEPTH)) ? mem[pc_s[7:0]] : 32'h0BAD_0BAD;
    end

    int          total = 0;
    int          bad   = 0;
    int          rises = 0;
    logic [31:0] m_pc;
    logic [31:0] m_instr;
    int          m_cnt;
    bit          stray_on;

    bit          c_jmp   [0:127];
    bit          c_br    [0:127];
    logic [15:0] c_imm   [0:127];
    logic [25:0] c_tgt   [0:127];
    int          c_stall [0:127];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic tick();
        logic prev;
        prev = instr_valid;
        @(posedge clk);
        #1;
        if (instr_valid && !prev) rises++;
    endtask

    task automatic chk_count(input string tag);
        chk(tag, retired_count, 64'(m_cnt));
        chk({tag, "_sat"}, cnt_s, (m_cnt > 3) ? 64'd3 : 64'(m_cnt));
    endtask

    // Inputs outside EXEC must be ignored; drive junk (or all-ones).
    task automatic drive_stray();
        if (stray_on) begin
            exec_done   = 1'b1;
            take_jump   = 1'b1;
            take_branch = 1'b1;
        end else begin
            exec_done   = 1'($urandom_range(0, 1));
            take_jump   = 1'($urandom_range(0, 1));
            take_branch = 1'($urandom_range(0, 1));
        end
        branch_imm  = 16'($urandom);
        jump_target = 26'($urandom);
    endtask

    task automatic clear_ctl();
        for (int i = 0; i < 128; i++) begin
            c_jmp[i] = 1'b0; c_br[i] = 1'b0; c_imm[i] = 16'd0;
            c_tgt[i] = 26'd0; c_stall[i] = 0;
        end
    endtask

    task automatic fill_plain();
        for (int i = 0; i < 256; i++) mem[i] = $urandom & 32'h7FFF_FFFF;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        drive_stray();
        tick();
        chk("rst_pc", pc, 64'd0);
        chk("rst_instr", instr, 64'd0);
        chk("rst_valid", instr_valid, 64'd0);
        chk("rst_halted", halted, 64'd0);
        chk("rst_fault", fault, 64'd0);
        chk("rst_cnt", retired_count, 64'd0);
        chk("rst_cnt_sat", cnt_s, 64'd0);
        rst   = 1'b0;
        m_pc  = 32'd0;
        m_cnt = 0;
        m_instr = 32'd0;
        rises = 0;
    endtask

    // Terminal state: nothing moves no matter what the inputs do.
    task automatic chk_hold(input bit exp_fault);
        for (int i = 0; i < 3; i++) begin
            drive_stray();
            tick();
            chk("hold_pc", pc, 64'(m_pc));
            chk("hold_instr", instr, 64'(m_instr));
            chk("hold_valid", instr_valid, 64'd0);
            chk("hold_halted", halted, 64'd1);
            chk("hold_fault", fault, 64'(exp_fault));
            chk_count("hold_cnt");
        end
    endtask

    task automatic run(input int max_steps);
        int step;
        bit done;
        logic [31:0] p1;
        step = 0;
        done = 1'b0;
        while (!done) begin
            drive_stray();
            tick();
            if (m_pc >= 32'(DEPTH)) begin
                chk("oob_halted", halted, 64'd1);
                chk("oob_fault", fault, 64'd1);
                chk("oob_pc", pc, 64'(m_pc));
                chk("oob_instr", instr, 64'(m_instr));
                chk("oob_valid", instr_valid, 64'd0);
                chk_count("oob_cnt");
                chk_hold(1'b1);
                done = 1'b1;
            end else begin
                chk("fetch_pc", pc, 64'(m_pc));
                chk("fetch_valid", instr_valid, 64'd0);
                chk_count("fetch_cnt");
                drive_stray();
                tick();
                m_instr = mem[m_pc[7:0]];
                if (m_instr == HALTW) begin
                    chk("halt_halted", halted, 64'd1);
                    chk("halt_fault", fault, 64'd0);
                    chk("halt_valid", instr_valid, 64'd0);
                    chk("halt_pc", pc, 64'(m_pc));
                    chk("halt_instr", instr, 64'(HALTW));
                    chk_count("halt_cnt");
                    chk_hold(1'b0);
                    done = 1'b1;
                end else begin
                    chk("exec_valid", instr_valid, 64'd1);
                    chk("exec_pc", pc, 64'(m_pc));
                    chk("exec_instr", instr, 64'(m_instr));
                    for (int s = 0; s < c_stall[step]; s++) begin
                        exec_done   = 1'b0;
                        take_jump   = 1'($urandom_range(0, 1));
                        take_branch = 1'($urandom_range(0, 1));
                        tick();
                        chk("stall_valid", instr_valid, 64'd1);
                        chk("stall_pc", pc, 64'(m_pc));
                    end
                    exec_done   = 1'b1;
                    take_jump   = c_jmp[step];
                    take_branch = c_br[step];
                    branch_imm  = c_imm[step];
                    jump_target = c_tgt[step];
                    tick();
                    p1 = m_pc + 32'd1;
                    if (c_jmp[step])     m_pc = {p1[31:26], c_tgt[step]};
                    else if (c_br[step]) m_pc = p1 + 32'($signed(c_imm[step]));
                    else                 m_pc = p1;
                    m_cnt++;
                    chk("done_valid", instr_valid, 64'd0);
                    chk("done_pc", pc, 64'(m_pc));
                    chk_count("done_cnt");
                    step++;
                    if (step >= max_steps) done = 1'b1;
                end
            end
        end
    endtask

    initial begin
        rst = 1'b1; exec_done = 1'b0; take_jump = 1'b0; take_branch = 1'b0;
        branch_imm = 16'd0; jump_target = 26'd0; stray_on = 1'b0;

        // Sequential program ending in the sentinel, with forced stray inputs.
        fill_plain(); mem[3] = HALTW; clear_ctl();
        for (int i = 0; i < 3; i++) c_stall[i] = 0;
        stray_on = 1'b1;
        do_reset();
        run(100);
        stray_on = 1'b0;
        chk("t1_pc", pc, 64'd3);
        chk("t1_cnt", retired_count, 64'd3);
        chk("t1_rises", 64'(rises), 64'd3);

        // Backward then forward branch.
        fill_plain(); mem[7] = HALTW; clear_ctl();
        c_br[5] = 1'b1; c_imm[5] = 16'hFFFC;
        c_br[6] = 1'b1; c_imm[6] = 16'h0004;
        c_stall[2] = 2;
        do_reset();
        run(100);
        chk("t2_pc", pc, 64'd7);
        chk("t2_cnt", retired_count, 64'd7);

        // Jump outranks a simultaneous branch.
        fill_plain(); mem[40] = HALTW; mem[11] = HALTW; clear_ctl();
        c_jmp[0] = 1'b1; c_tgt[0] = 26'd10;
        c_jmp[1] = 1'b1; c_br[1] = 1'b1; c_tgt[1] = 26'd40; c_imm[1] = 16'd1;
        do_reset();
        run(100);
        chk("t3_pc", pc, 64'd40);
        chk("t3_cnt", retired_count, 64'd2);

        // Jump out of range faults on the following fetch.
        fill_plain(); clear_ctl();
        c_jmp[0] = 1'b1; c_tgt[0] = 26'd200;
        do_reset();
        run(100);
        chk("t4_pc", pc, 64'd200);
        chk("t4_fault", fault, 64'd1);
        chk("t4_cnt", retired_count, 64'd1);
        chk("t4_rises", 64'(rises), 64'd1);

        // Long stall mid-EXEC, then reset and restart from 0.
        fill_plain(); clear_ctl();
        do_reset();
        run(2);
        drive_stray(); tick();
        drive_stray(); tick();
        chk("t5_valid", instr_valid, 64'd1);
        chk("t5_pc", pc, 64'd2);
        for (int i = 0; i < 20; i++) begin
            exec_done = 1'b0; take_jump = 1'b1; take_branch = 1'b1;
            tick();
            chk("t5_stall_valid", instr_valid, 64'd1);
            chk("t5_stall_pc", pc, 64'd2);
        end
        do_reset();
        mem[1] = HALTW;
        run(100);
        chk("t5_pc", pc, 64'd1);
        chk("t5_cnt", retired_count, 64'd1);

        // Random programs and control outcomes.
        for (int t = 0; t < 10; t++) begin
            for (int i = 0; i < 256; i++)
                mem[i] = ($urandom_range(0, 19) == 0) ? HALTW : ($urandom & 32'h7FFF_FFFF);
            mem[0] = 32'h1234_5678;
            for (int i = 0; i < 128; i++) begin
                int d;
                d = int'($urandom_range(0, 40)) - 20;
                c_jmp[i]   = ($urandom_range(0, 99) < 15);
                c_br[i]    = ($urandom_range(0, 99) < 30);
                c_imm[i]   = 16'(d);
                c_tgt[i]   = 26'($urandom_range(0, 220));
                c_stall[i] = int'($urandom_range(0, 3));
            end
            do_reset();
            run(60);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fetch_sequencer.md
Name: fetch_sequencer

Overview:
- Upstream companion to the instruction memory in the non-pipelined MIPS core.
- Owns the word-indexed program counter and drives it into the instruction memory, which has one-cycle registered read latency.
- Captures the returned word and presents it to the decode/execute datapath with a valid/done handshake.
- Computes the next PC from sequential, branch or jump outcomes, and stops on the halt sentinel word or an out-of-range PC.

Parameters:
- PC_RESET, 0, PC value loaded on reset.
- MEM_DEPTH, 151, number of instruction words; any PC >= MEM_DEPTH is a fault.
- HALT_WORD, 32'hFFFFFFFF, sentinel instruction that ends the program.
- CNT_W, 32, width of the retired-instruction counter.

Ports:
- clk  input  1  system clock, all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- mem_instr  input  32  registered read data from instruction memory, valid on the cycle after pc is presented.
- exec_done  input  1  datapath has finished the current instruction; sampled only in EXEC.
- take_branch  input  1  current instruction is a taken branch; qualified by exec_done.
- take_jump  input  1  current instruction is a jump; qualified by exec_done.
- branch_imm  input  16  signed branch offset in words.
- jump_target  input  26  jump target word index.
- pc  output  32  current PC, also the instruction memory address.
- instr  output  32  captured instruction.
- instr_valid  output  1  high throughout EXEC.
- halted  output  1  sticky; set on sentinel or fault.
- fault  output  1  sticky; set only on out-of-range PC.
- retired_count  output  CNT_W  number of instructions completed.

Behaviour:
- Reset (rst high at an edge, any state, including mid-EXEC):
  - Next-cycle values: pc=PC_RESET, instr=0, instr_valid=0, halted=0, fault=0, retired_count=0, state=FETCH.
  - rst has priority over every other input.
- State machine: FETCH -> CAPTURE -> EXEC -> FETCH, plus a terminal HALT state.
- FETCH (1 cycle):
  - pc is held stable; the instruction memory samples it at the closing edge.
  - If pc >= MEM_DEPTH: go to HALT with fault=1 and halted=1; instr is unchanged.
- CAPTURE (1 cycle):
  - instr <= mem_instr at the closing edge.
  - If mem_instr == HALT_WORD: go to HALT with halted=1 and fault=0. The sentinel is not counted as retired and instr_valid never rises for it.
  - Otherwise go to EXEC.
- EXEC:
  - instr_valid=1; wait indefinitely for exec_done.
  - On the edge where exec_done=1, the next pc is chosen by priority:
    - take_jump=1: {pc_plus1[31:26], jump_target}.
    - else take_branch=1: pc_plus1 + sign_extend(branch_imm).
    - else: pc_plus1.
  - pc_plus1 = pc+1. Jump wins when jump and branch are asserted together. All arithmetic is 32-bit wrap-around with no overflow flag.
  - On that same edge: retired_count increments (saturates at all-ones), instr_valid drops, state goes to FETCH.
  - take_branch, take_jump, branch_imm and jump_target are ignored when exec_done=0 or the state is not EXEC.
  - exec_done is ignored outside EXEC.
- Minimum issue latency: 3 cycles per instruction (FETCH, CAPTURE, 1-cycle EXEC). First instr_valid appears 2 cycles after rst deasserts.
- HALT:
  - Terminal: pc, instr and retired_count hold; instr_valid=0.
  - Only rst leaves HALT.
- Branch to a negative or wrapped PC is not special-cased: the next FETCH detects pc >= MEM_DEPTH and faults.

Test Plan:
1. Sequential: memory words 0..2 are ordinary instructions and word 3 = 32'hFFFFFFFF; exec_done pulses for one cycle in each EXEC -> pc steps 0,1,2,3; halted=1, fault=0, retired_count=3; instr_valid high exactly 3 times.
2. Branch: at pc=5, take_branch=1 with branch_imm=16'hFFFC -> next pc=2. At pc=2, take_branch=1 with branch_imm=16'h0004 -> next pc=7.
3. Jump priority: at pc=10, take_jump=1, take_branch=1, jump_target=26'd40, branch_imm=1 -> next pc=40.
4. Fault: jump to target 200 -> next FETCH sets halted=1 and fault=1; pc holds 200; instr_valid never asserts; retired_count includes the jump.
5. Stall and reset mid-EXEC: exec_done held low for 20 cycles -> instr_valid stays high and pc is unchanged. Then rst for 1 cycle -> next cycle pc=0, retired_count=0, instr_valid=0, halted=0; fetch restarts from 0.
6. Stray inputs: exec_done=1 and take_jump=1 during FETCH/CAPTURE -> no pc change and no count change.
